// File: rtl/cpu_wb_arbiter.sv
// cpu_wb_arbiter: arbitrates the COM-stage register-file write port between
// the pipeline (p4), buffered load returns and the iterative divider.
// Optional build macro: WB_BYPASS_EN. When defined, a load arriving while the
// pipeline slot and FIFO are both empty writes straight through without being
// queued. When undefined, every load with a nonzero destination goes through
// the FIFO.
module cpu_wb_arbiter #(
    parameter int FIFO_DEPTH   = 4,
    parameter int STALL_THRESH = 3,
    parameter int DIV_STARVE   = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  p4_dest,
    input  logic        p4_dest_zero,
    input  logic [31:0] p4_result,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [4:0]  mem_dest,
    input  logic [31:0] mem_result,
    input  logic        div_valid,
    output logic        div_ready,
    input  logic [4:0]  div_dest,
    input  logic [31:0] div_result,
    output logic        stall_req,
    output logic        p5u_write,
    output logic [4:0]  p5u_dest_reg,
    output logic [31:0] p5u_result,
    output logic [31:0] p5_result,
    output logic [31:0] p5_pending
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(DIV_STARVE + 1);

    logic [4:0]    dest_q [FIFO_DEPTH];
    logic [31:0]   data_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_next;
    logic [SW-1:0] starve, starve_next;

    logic empty, full, mem_wr, div_wr;
    logic g_p4, g_fifo, g_byp, g_div;
    logic enq, deq;

    assign empty     = (count == '0);
    assign full      = (count == CW'(FIFO_DEPTH));
    // Occupancy is registered, so a full FIFO refuses a beat even while it dequeues.
    assign mem_ready = ~full;
    assign mem_wr    = mem_valid & (mem_dest != 5'd0);
    assign div_wr    = div_valid & (div_dest != 5'd0);

    assign g_p4   = ~p4_dest_zero;
    assign g_fifo = ~g_p4 & ~empty;
`ifdef WB_BYPASS_EN
    assign g_byp  = ~g_p4 & empty & mem_wr;
`else
    assign g_byp  = 1'b0;
`endif
    assign g_div  = ~g_p4 & ~g_fifo & ~g_byp & div_wr;

    // A zero-destination divider result is consumed without a write.
    assign div_ready = g_div | (div_valid & (div_dest == 5'd0));
    assign enq       = mem_wr & mem_ready & ~g_byp;
    assign deq       = g_fifo;

    // Write-port mux driven by the single granted source.
    always_comb begin
        p5u_write    = 1'b0;
        p5u_dest_reg = 5'd0;
        p5u_result   = 32'd0;
        if (g_p4) begin
            p5u_write    = 1'b1;
            p5u_dest_reg = p4_dest;
            p5u_result   = p4_result;
        end else if (g_fifo) begin
            p5u_write    = 1'b1;
            p5u_dest_reg = dest_q[rd_ptr];
            p5u_result   = data_q[rd_ptr];
        end else if (g_byp) begin
            p5u_write    = 1'b1;
            p5u_dest_reg = mem_dest;
            p5u_result   = mem_result;
        end else if (g_div) begin
            p5u_write    = 1'b1;
            p5u_dest_reg = div_dest;
            p5u_result   = div_result;
        end
    end

    // Next occupancy and saturating divider-starvation count.
    always_comb begin
        count_next = count;
        if (enq && !deq)
            count_next = count + CW'(1);
        else if (deq && !enq)
            count_next = count - CW'(1);
        starve_next = '0;
        if (div_valid && !div_ready)
            starve_next = (starve == SW'(DIV_STARVE)) ? starve : starve + SW'(1);
    end

    // Pending mask: one-hot decode of every live FIFO entry's destination.
    always_comb begin
        p5_pending = 32'd0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if ({1'b0, AW'(AW'(i) - rd_ptr)} < count)
                p5_pending = p5_pending | (32'd1 << dest_q[i]);
        end
        p5_pending[0] = 1'b0;
    end

    // FIFO payload storage; validity is tracked by count, so no reset needed.
    always_ff @(posedge clock) begin
        if (enq) begin
            dest_q[wr_ptr] <= mem_dest;
            data_q[wr_ptr] <= mem_result;
        end
    end

    // Pointers, occupancy, starvation counter, stall request and p5 register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            starve    <= '0;
            stall_req <= 1'b0;
            p5_result <= 32'd0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + AW'(1);
            if (deq) rd_ptr <= rd_ptr + AW'(1);
            count     <= count_next;
            starve    <= starve_next;
            stall_req <= (count_next >= CW'(STALL_THRESH)) ||
                         (starve_next == SW'(DIV_STARVE));
            p5_result <= p5u_result;
        end
    end

endmodule

// File: doc/cpu_wb_arbiter.md
Name: cpu_wb_arbiter

Overview:
- Schedules the single register-file write port in the COM stage between three requesters: the pipeline (ALU/multiplier result from p4), load returns from the readpath, and the iterative divider.
- Load returns are buffered in a small FIFO, so loads never block the readpath while the pipeline owns the port.
- The block raises a stall request when loads back up or the divider starves.
- It also exports a pending-register mask so hazard logic can protect register writes still queued in the FIFO.

Parameters:
- FIFO_DEPTH, 4, load-return FIFO entries; must be a power of 2, at least 2.
- STALL_THRESH, 3, FIFO occupancy at or above which stall_req asserts; must be 1 to FIFO_DEPTH.
- DIV_STARVE, 8, consecutive ungranted div_valid cycles before stall_req asserts; must be at least 1.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- p4_dest  in  5  pipeline destination register.
- p4_dest_zero  in  1  1 = pipeline slot carries no register write.
- p4_result  in  32  pipeline result (ALU or multiplier, already selected).
- mem_valid  in  1  load-return beat valid.
- mem_ready  out  1  load-return beat accepted when mem_valid and mem_ready are both 1.
- mem_dest  in  5  load destination register.
- mem_result  in  32  load data.
- div_valid  in  1  divider result valid; held until accepted.
- div_ready  out  1  divider result consumed this cycle.
- div_dest  in  5  divider destination register.
- div_result  in  32  divider quotient or remainder.
- stall_req  out  1  registered; request to the pipeline to issue bubbles.
- p5u_write  out  1  register-file write enable (combinational, lands at next edge).
- p5u_dest_reg  out  5  write address; 0 when p5u_write=0.
- p5u_result  out  32  write data / bypass value; 0 when p5u_write=0.
- p5_result  out  32  p5u_result registered.
- p5_pending  out  32  bit r = 1 if a FIFO entry targets register r; bit 0 is always 0.

Behaviour:
- Reset values: FIFO empty, starve counter 0, stall_req=0, p5_result=0, p5_pending=0, mem_ready=1, div_ready=0.
- Grant priority each cycle (combinational):
  1. Pipeline, when p4_dest_zero=0.
  2. FIFO head, when the FIFO is non-empty.
  3. Incoming mem beat, through the bypass path (see Optional Feature).
  4. Divider, when div_valid=1.
- Only one grant per cycle. The granted source drives p5u_*, and p5u_write=1.
- mem_ready = not full, taken from the registered occupancy only.
  - A full FIFO refuses a beat even in a cycle where it also dequeues.
- Enqueue happens at the clock edge when mem_valid, mem_ready, mem_dest≠0, and the beat was not bypassed.
- A mem beat with mem_dest=0 is accepted and discarded; it produces no write.
- Dequeue happens at the clock edge when the FIFO head is granted.
- Simultaneous enqueue and dequeue leaves the count unchanged; pointers wrap modulo FIFO_DEPTH.
- FIFO order is preserved: loads retire in arrival order.
- div_ready=1 only in the cycle the divider is granted, or when div_valid=1 and div_dest=0 (result discarded, no write).
- Starve counter:
  - Increments on each cycle with div_valid=1 and div_ready=0, saturating at DIV_STARVE.
  - Clears when div_ready=1 or div_valid=0.
- stall_req next value is 1 when either:
  - next FIFO occupancy is at least STALL_THRESH, or
  - the next starve count equals DIV_STARVE.
- The pipeline issues p4_dest_zero=1 from the cycle after it samples stall_req=1. Arbitration does not depend on that compliance.
- p5_pending is the OR of one-hot decodes of the valid FIFO entries' dest fields. It is a combinational function of the registered FIFO state.
- p5_result <= p5u_result every edge.
- Reset asserted mid-operation: queued loads are dropped and all state returns to reset values immediately (asynchronous).

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: when the pipeline slot is empty, the FIFO is empty and mem_valid=1, the mem beat writes directly through p5u_* with zero added latency and is not enqueued.
- Undefined: every load with mem_dest≠0 passes through the FIFO, adding a minimum of one cycle of latency.
- Priority between pipeline and divider is the same in both builds.

Test Plan:
- Reset low, then release -> mem_ready=1, stall_req=0, p5_pending=0, p5u_write=0.
- Pipeline writes x5=0x11 each cycle while mem returns x7=0xA0, x8=0xA1, x9=0xA2 -> all three loads enqueued, p5_pending bits 7,8,9 set, stall_req=1 the cycle after the third enqueue. Then the pipeline goes idle -> x7, x8, x9 written in order on consecutive cycles.
- FIFO full (4 entries) plus mem_valid=1 with a simultaneous dequeue -> mem_ready=0 and the beat is not taken; the beat is taken the next cycle.
- Pipeline busy every cycle with div_valid=1 for x3=0x42 -> stall_req=1 after 8 ungranted cycles; the first empty pipeline slot writes x3=0x42 and div_ready=1.
- mem beat with mem_dest=0 and a div result with div_dest=0 -> both accepted, no write, p5_pending unchanged.
- With WB_BYPASS_EN: idle pipeline, empty FIFO, mem x12=0xDEAD -> p5u_write=1 in the same cycle, p5_result=0xDEAD next cycle. Without WB_BYPASS_EN -> the write occurs one cycle later.
